// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the current PC and issues a one-cycle read to instruction memory.
// It presents the returned word to decode with a valid/ready handshake,
// then waits for the branching stage to supply the next PC.
// Memory is word-addressed. A HALT_OP opcode ends fetching until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_next,
  input  logic        pc_next_valid,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_cur,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        busy,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_RESOLVE = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic        req_q, req_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;

  // Accepted-instruction counter; wraps naturally at 16 bits.
  function automatic logic [15:0] count_inc(input logic [15:0] c);
    return c + 16'd1;
  endfunction

  // True when the opcode field marks the stop instruction.
  function automatic logic is_halt(input logic [5:0] opcode);
    return (opcode == HALT_OP);
  endfunction

  // The handshake only completes while a word is actually being offered.
  assign accept = vld_q & instr_ready;

  // Next-state and next-output selection for the fetch sequence.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    req_d    = 1'b0;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          addr_d  = RESET_PC;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The request pulse lasts exactly this one cycle; any early rvalid is dropped.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          vld_d = 1'b0;
          cnt_d = count_inc(cnt_q);
          if (is_halt(instr_q[31:26])) begin
            // A stop instruction wins over a same-cycle branch result.
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (pc_next_valid) begin
            pc_d    = pc_next;
            addr_d  = pc_next;
            req_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (pc_next_valid) begin
          pc_d    = pc_next;
          addr_d  = pc_next;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to the idle, all-zero view.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr   = addr_q;
  assign imem_req    = req_q;
  assign instr_out   = instr_q;
  assign pc_cur      = pc_q;
  assign instr_valid = vld_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a behavioural model compared every cycle,
// and hand-computed literal expectations at key points.
module tb_fetch_unit;

  localparam logic [5:0] HALT_CODE = 6'b111111;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc_next;
  logic        pc_next_valid;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr_out;
  logic [31:0] pc_cur;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        busy;
  logic [15:0] fetch_count;

  // memory responder and manual rvalid injection
  logic        mem_en;
  int          mem_lat;
  logic [31:0] mem_halt_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        man_rvalid;
  logic [31:0] man_rdata;

  assign imem_rvalid = mem_rvalid | man_rvalid;
  assign imem_rdata  = man_rvalid ? man_rdata : mem_rdata;

  // behavioural model state
  logic        m_run = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_req = 1'b0;
  logic        m_need_data = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_need_pc = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [15:0] m_count = '0;
  logic        preload_req;
  logic [15:0] preload_val;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pc_next       (pc_next),
    .pc_next_valid (pc_next_valid),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .instr_out     (instr_out),
    .pc_cur        (pc_cur),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .halted        (halted),
    .busy          (busy),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == mem_halt_addr) return 32'hFC00_0000;
    case (a)
      32'd0:   return 32'h0000_0011;
      32'd1:   return 32'h0000_0022;
      32'd2:   return 32'h0000_0033;
      default: return 32'h0100_0000 | (a & 32'h00FF_FFFF);
    endcase
  endfunction

  // Memory: answers each request mem_lat cycles later with a one-cycle rvalid.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && mem_en) begin
        logic [31:0] a;
        a = imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  // Model: what the fetch stage is waiting for, advanced once per clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_run       <= 1'b0;
      m_halted    <= 1'b0;
      m_req       <= 1'b0;
      m_need_data <= 1'b0;
      m_valid     <= 1'b0;
      m_need_pc   <= 1'b0;
      m_pc        <= '0;
      m_instr     <= '0;
      m_count     <= '0;
    end else if (preload_req) begin
      m_count <= preload_val;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1;
        m_pc  <= 32'h0000_0000;
        m_req <= 1'b1;
      end
    end else if (m_req) begin
      m_req       <= 1'b0;
      m_need_data <= 1'b1;
    end else if (m_need_data) begin
      if (imem_rvalid) begin
        m_need_data <= 1'b0;
        m_valid     <= 1'b1;
        m_instr     <= imem_rdata;
      end
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid <= 1'b0;
        m_count <= m_count + 16'd1;
        if (m_instr[31:26] == HALT_CODE) begin
          m_halted <= 1'b1;
          m_run    <= 1'b0;
        end else if (pc_next_valid) begin
          m_pc  <= pc_next;
          m_req <= 1'b1;
        end else begin
          m_need_pc <= 1'b1;
        end
      end
    end else if (m_need_pc) begin
      if (pc_next_valid) begin
        m_need_pc <= 1'b0;
        m_pc      <= pc_next;
        m_req     <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic idle;
    idle = !m_run && !m_halted;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    if (idle)  chk("imem_addr_idle", imem_addr, 32'd0);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("instr_out", instr_out, m_instr);
    chk("pc_cur", pc_cur, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_count});
  endtask

  // One clock: compare on the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: instr_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    int n;
    int reqs;
    rst = 1'b1; start = 1'b0; pc_next = '0; pc_next_valid = 1'b0; instr_ready = 1'b0;
    mem_en = 1'b1; mem_lat = 1; mem_halt_addr = 32'hFFFF_FFF0;
    man_rvalid = 1'b0; man_rdata = '0; preload_req = 1'b0; preload_val = '0;

    // T1 reset then start
    step(); step();
    chk("t1_rst_addr", imem_addr, 32'd0);
    chk("t1_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t1_rst_instr", instr_out, 32'd0);
    chk("t1_rst_pc", pc_cur, 32'd0);
    chk("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_rst_halted", {31'd0, halted}, 32'd0);
    chk("t1_rst_busy", {31'd0, busy}, 32'd0);
    chk("t1_rst_count", {16'd0, fetch_count}, 32'd0);
    rst = 1'b0; start = 1'b1;
    instr_ready = 1'b1; pc_next_valid = 1'b1; pc_next = 32'd1;
    step();
    start = 1'b0;
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    step();
    chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
    chk("t1_wait_busy", {31'd0, busy}, 32'd1);

    // T2 sequential fetch
    for (int i = 0; i < 3; i++) begin
      pc_next = i + 1;
      wait_valid("t2_valid", n);
      if (i > 0) chk("t2_gap", n, 32'd2);
      chk("t2_instr", instr_out, 32'h11 * (i + 1));
      chk("t2_pc", pc_cur, i);
      step();
    end
    chk("t2_count", {16'd0, fetch_count}, 32'd3);
    chk("t2_next_addr", imem_addr, 32'd3);

    // T3 backpressure
    instr_ready = 1'b0; pc_next_valid = 1'b0;
    wait_valid("t3_valid", n);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid_hold", {31'd0, instr_valid}, 32'd1);
      chk("t3_instr_hold", instr_out, 32'h0100_0003);
      chk("t3_pc_hold", pc_cur, 32'd3);
      chk("t3_no_req", {31'd0, imem_req}, 32'd0);
    end
    chk("t3_count_before", {16'd0, fetch_count}, 32'd3);
    instr_ready = 1'b1;
    step();
    chk("t3_count_after", {16'd0, fetch_count}, 32'd4);
    chk("t3_valid_drop", {31'd0, instr_valid}, 32'd0);

    // T4 late branch resolve, ignored pulse during WAIT
    step(); step(); step();
    chk("t4_resolve_busy", {31'd0, busy}, 32'd1);
    chk("t4_resolve_noreq", {31'd0, imem_req}, 32'd0);
    mem_lat = 3; pc_next_valid = 1'b1; pc_next = 32'h40;
    step();
    pc_next_valid = 1'b0;
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h40);
    step();
    pc_next_valid = 1'b1; pc_next = 32'h99;
    step();
    pc_next_valid = 1'b0;
    wait_valid("t4_valid", n);
    chk("t4_pc", pc_cur, 32'h40);
    chk("t4_instr", instr_out, 32'h0100_0040);
    step();
    chk("t4_count", {16'd0, fetch_count}, 32'd5);

    // T5 halt
    mem_lat = 1; mem_halt_addr = 32'h50;
    pc_next_valid = 1'b1; pc_next = 32'h50;
    step();
    wait_valid("t5_valid", n);
    chk("t5_instr", instr_out, 32'hFC00_0000);
    step();
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_count", {16'd0, fetch_count}, 32'd6);
    start = 1'b1; pc_next = 32'h60; man_rvalid = 1'b1; man_rdata = 32'hAAAA_AAAA;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (imem_req) reqs++;
    end
    start = 1'b0; pc_next_valid = 1'b0; man_rvalid = 1'b0;
    chk("t5_no_req", reqs, 32'd0);
    chk("t5_still_halted", {31'd0, halted}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_halted", {31'd0, halted}, 32'd0);
    chk("t5_rst_count", {16'd0, fetch_count}, 32'd0);

    // T6 reset during WAIT, late rvalid ignored
    mem_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
    step();
    man_rvalid = 1'b0;
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_instr", instr_out, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    step();

    // T6 counter wrap
    mem_en = 1'b1; instr_ready = 1'b1; pc_next_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t6w_valid", n);
    step();
    chk("t6w_count1", {16'd0, fetch_count}, 32'd1);
    @(negedge clk);
    #1;
    force dut.cnt_q = 16'hFFFD;
    preload_val = 16'hFFFD; preload_req = 1'b1;
    #1;
    release dut.cnt_q;
    @(posedge clk);
    #1;
    preload_req = 1'b0;
    pc_next_valid = 1'b1; pc_next = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      wait_valid("t6w_valid_loop", n);
      chk("t6w_instr", instr_out, 32'h0100_0100);
      step();
      chk("t6w_count", {16'd0, fetch_count}, (i == 2) ? 32'd0 : (32'hFFFE + i));
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
